// File: rtl/branch_presolve_fw_if.sv
// branch_presolve_fw_if
//   Bundles the fetch-side pack input, the decode-side pack output, the
//   predictor result, the redirect port and the flush/ack controls of the
//   branch pre-decode stage.
//   slave  : view used by branch_presolve_fw (consumes io_i_*, drives io_o_*
//            and io_i_pack_ready)
//   master : view used by whoever drives the stage (fetch / PC gen / tb)
interface branch_presolve_fw_if #(
  parameter int FETCH_WIDTH = 2,
  parameter int XLEN        = 64,
  parameter int CNT_W       = 16
);
  localparam int SEL_W = $clog2(FETCH_WIDTH);

  logic                      io_i_flush;
  logic                      io_i_redirect_ack;
  logic                      io_i_pack_valid;
  logic                      io_i_pack_ready;
  logic [FETCH_WIDTH-1:0]    io_i_pack_valids;
  logic [XLEN-1:0]           io_i_pack_pc;
  logic [32*FETCH_WIDTH-1:0] io_i_pack_insts;
  logic                      io_i_bp_valid;
  logic [SEL_W-1:0]          io_i_bp_select;
  logic                      io_i_bp_taken;
  logic                      io_o_pack_valid;
  logic                      io_o_pack_ready;
  logic [FETCH_WIDTH-1:0]    io_o_pack_valids;
  logic [XLEN-1:0]           io_o_pack_pc;
  logic [32*FETCH_WIDTH-1:0] io_o_pack_insts;
  logic                      io_o_redirect_valid;
  logic [XLEN-1:0]           io_o_redirect_pc;
  logic                      io_o_redirect_taken;
  logic [CNT_W-1:0]          io_o_redirect_count;

  modport master (
    output io_i_flush, io_i_redirect_ack, io_i_pack_valid, io_i_pack_valids,
           io_i_pack_pc, io_i_pack_insts, io_i_bp_valid, io_i_bp_select,
           io_i_bp_taken, io_o_pack_ready,
    input  io_i_pack_ready, io_o_pack_valid, io_o_pack_valids, io_o_pack_pc,
           io_o_pack_insts, io_o_redirect_valid, io_o_redirect_pc,
           io_o_redirect_taken, io_o_redirect_count
  );

  modport slave (
    input  io_i_flush, io_i_redirect_ack, io_i_pack_valid, io_i_pack_valids,
           io_i_pack_pc, io_i_pack_insts, io_i_bp_valid, io_i_bp_select,
           io_i_bp_taken, io_o_pack_ready,
    output io_i_pack_ready, io_o_pack_valid, io_o_pack_valids, io_o_pack_pc,
           io_o_pack_insts, io_o_redirect_valid, io_o_redirect_pc,
           io_o_redirect_taken, io_o_redirect_count
  );
endinterface

// File: rtl/branch_presolve_fw.sv
// branch_presolve_fw
//   Registered branch pre-decode stage between fetch and decode. Each fetch
//   pack is scanned lane by lane: false-taken predictions are corrected to the
//   fall-through, JAL targets are resolved early, and a one-cycle redirect is
//   issued together with the (truncated) pack. After a redirect the stage
//   swallows wrong-path packs until the PC generator acknowledges.
// Ports
//   clock    : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   io       : branch_presolve_fw_if.slave (pack in/out handshake, predictor
//              result, flush, redirect ack, redirect pulse/pc/taken/count)
module branch_presolve_fw #(
  parameter int FETCH_WIDTH = 2,
  parameter int XLEN        = 64,
  parameter int CNT_W       = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  branch_presolve_fw_if.slave io
);
  localparam int SEL_W = $clog2(FETCH_WIDTH);
  localparam int OFF   = $clog2(FETCH_WIDTH * 4);
  localparam int IW    = 32 * FETCH_WIDTH;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_WAIT_ACK = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic                   o_valid_q, o_valid_d;
  logic [FETCH_WIDTH-1:0] o_valids_q, o_valids_d;
  logic [XLEN-1:0]        o_pc_q, o_pc_d;
  logic [IW-1:0]          o_insts_q, o_insts_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [XLEN-1:0]        rd_pc_q, rd_pc_d;
  logic                   rd_taken_q, rd_taken_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  // Mask with lanes 0..k set: used to truncate a pack after a control transfer.
  function automatic logic [FETCH_WIDTH-1:0] lanes_upto(input logic [SEL_W-1:0] k);
    logic [FETCH_WIDTH-1:0] m;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      m[i] = (i <= int'(k));
    end
    return m;
  endfunction

  logic [XLEN-1:0]        base_pc;
  logic [XLEN-1:0]        lane_pc  [FETCH_WIDTH];
  logic [XLEN-1:0]        lane_imm [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0] lane_cf;
  logic [FETCH_WIDTH-1:0] lane_jal;

  // Lane PCs are relative to the pack-aligned base, regardless of fetch PC alignment.
  assign base_pc = {io.io_i_pack_pc[XLEN-1:OFF], {OFF{1'b0}}};

  for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_lane
    logic [6:0] opc;
    logic [2:0] f3;
    assign opc = io.io_i_pack_insts[32*g +: 7];
    assign f3  = io.io_i_pack_insts[32*g+12 +: 3];
    assign lane_pc[g] = base_pc + XLEN'(4 * g);
    // J-type immediate, sign-extended from instruction bit 31.
    assign lane_imm[g] = {{(XLEN-20){io.io_i_pack_insts[32*g+31]}},
                          io.io_i_pack_insts[32*g+12 +: 8],
                          io.io_i_pack_insts[32*g+20],
                          io.io_i_pack_insts[32*g+21 +: 10],
                          1'b0};
    assign lane_jal[g] = io.io_i_pack_valids[g] & (opc == 7'b1101111);
    // funct3 010/011 are not defined branches, so they do not count as control flow.
    assign lane_cf[g]  = io.io_i_pack_valids[g] &
                         (((opc == 7'b1100011) && (f3 != 3'b010) && (f3 != 3'b011)) ||
                          (opc == 7'b1101111) ||
                          ((opc == 7'b1100111) && (f3 == 3'b000)));
  end

  logic                   pred;
  logic [SEL_W-1:0]       sel;
  logic                   jal_found;
  logic [SEL_W-1:0]       jal_idx;
  logic                   dec_redirect;
  logic                   dec_taken;
  logic [XLEN-1:0]        dec_pc;
  logic [FETCH_WIDTH-1:0] dec_valids;

  // Redirect decision for the pack currently on the input port.
  always_comb begin
    pred         = io.io_i_bp_valid & io.io_i_bp_taken;
    sel          = io.io_i_bp_select;
    jal_found    = 1'b0;
    jal_idx      = {SEL_W{1'b0}};
    dec_redirect = 1'b0;
    dec_taken    = 1'b0;
    dec_pc       = {XLEN{1'b0}};
    dec_valids   = io.io_i_pack_valids;
    // Scan from the top so the lowest JAL lane is the one left standing.
    for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
      if (lane_jal[i]) begin
        jal_found = 1'b1;
        jal_idx   = SEL_W'(i);
      end else begin
        jal_found = jal_found;
      end
    end
    if (jal_found && (!pred || (jal_idx < sel))) begin
      dec_redirect = 1'b1;
      dec_taken    = 1'b1;
      dec_pc       = lane_pc[jal_idx] + lane_imm[jal_idx];
      dec_valids   = io.io_i_pack_valids & lanes_upto(jal_idx);
    end else if (pred && !lane_cf[sel]) begin
      dec_redirect = 1'b1;
      dec_pc       = lane_pc[sel] + XLEN'(3'd4);
      dec_valids   = io.io_i_pack_valids & lanes_upto(sel);
    end else if (pred) begin
      dec_valids   = io.io_i_pack_valids & lanes_upto(sel);
    end else begin
      dec_valids   = io.io_i_pack_valids;
    end
  end

  logic pack_ready;
  logic accept;

  // Handshake, FSM next state and output-register next values.
  always_comb begin
    state_d    = state_q;
    o_valid_d  = o_valid_q;
    o_valids_d = o_valids_q;
    o_pc_d     = o_pc_q;
    o_insts_d  = o_insts_q;
    rd_valid_d = 1'b0;
    rd_pc_d    = rd_pc_q;
    rd_taken_d = rd_taken_q;
    cnt_d      = cnt_q;
    pack_ready = 1'b0;

    if (io.io_i_flush) begin
      pack_ready = 1'b0;
    end else if (state_q == ST_RUN) begin
      pack_ready = !o_valid_q | io.io_o_pack_ready;
    end else begin
      // While waiting for the ack, wrong-path packs are drained unconditionally.
      pack_ready = 1'b1;
    end
    accept = io.io_i_pack_valid & pack_ready;

    if (io.io_i_flush) begin
      state_d   = ST_RUN;
      o_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (accept) begin
            o_valid_d  = 1'b1;
            o_valids_d = dec_valids;
            o_pc_d     = io.io_i_pack_pc;
            o_insts_d  = io.io_i_pack_insts;
            if (dec_redirect) begin
              rd_valid_d = 1'b1;
              rd_pc_d    = dec_pc;
              rd_taken_d = dec_taken;
              state_d    = ST_WAIT_ACK;
            end else begin
              rd_valid_d = 1'b0;
            end
          end else if (io.io_o_pack_ready) begin
            o_valid_d = 1'b0;
          end else begin
            o_valid_d = o_valid_q;
          end
        end
        ST_WAIT_ACK: begin
          if (io.io_o_pack_ready) begin
            o_valid_d = 1'b0;
          end else begin
            o_valid_d = o_valid_q;
          end
          if (io.io_i_redirect_ack) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_WAIT_ACK;
          end
        end
        default: begin
          state_d   = ST_RUN;
          o_valid_d = 1'b0;
        end
      endcase
    end

    // Count moves with the pulse; sticks at all-ones.
    if (rd_valid_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      o_valid_q  <= 1'b0;
      o_valids_q <= {FETCH_WIDTH{1'b0}};
      o_pc_q     <= {XLEN{1'b0}};
      o_insts_q  <= {IW{1'b0}};
      rd_valid_q <= 1'b0;
      rd_pc_q    <= {XLEN{1'b0}};
      rd_taken_q <= 1'b0;
      cnt_q      <= {CNT_W{1'b0}};
    end else begin
      state_q    <= state_d;
      o_valid_q  <= o_valid_d;
      o_valids_q <= o_valids_d;
      o_pc_q     <= o_pc_d;
      o_insts_q  <= o_insts_d;
      rd_valid_q <= rd_valid_d;
      rd_pc_q    <= rd_pc_d;
      rd_taken_q <= rd_taken_d;
      cnt_q      <= cnt_d;
    end
  end

  assign io.io_i_pack_ready     = pack_ready;
  assign io.io_o_pack_valid     = o_valid_q;
  assign io.io_o_pack_valids    = o_valids_q;
  assign io.io_o_pack_pc        = o_pc_q;
  assign io.io_o_pack_insts     = o_insts_q;
  assign io.io_o_redirect_valid = rd_valid_q;
  assign io.io_o_redirect_pc    = rd_pc_q;
  assign io.io_o_redirect_taken = rd_taken_q;
  assign io.io_o_redirect_count = cnt_q;
endmodule

// File: tb/tb_branch_presolve_fw.sv
// tb_branch_presolve_fw
//   Directed scenarios with known answers, then randomized traffic compared
//   every cycle against a behavioural model of the pre-decode stage.
module tb_branch_presolve_fw;
  localparam int FW  = 2;
  localparam int XL  = 64;
  localparam int CW  = 2;
  localparam int SW  = $clog2(FW);
  localparam int CNT_MAX = (1 << CW) - 1;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h0010_0093;
  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] BNE  = 32'h0000_1063;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  branch_presolve_fw_if #(.FETCH_WIDTH(FW), .XLEN(XL), .CNT_W(CW)) io();
  branch_presolve_fw #(.FETCH_WIDTH(FW), .XLEN(XL), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n), .io(io)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  bit             m_valid, m_wait, m_rd_valid, m_rd_taken;
  logic [FW-1:0]  m_valids;
  logic [XL-1:0]  m_pc, m_rd_pc;
  logic [32*FW-1:0] m_insts;
  int             m_cnt;

  function automatic logic [31:0] enc_jal(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic bit ref_is_cf(input logic [31:0] ins);
    logic [6:0] op; logic [2:0] f3;
    op = ins[6:0]; f3 = ins[14:12];
    if (op == 7'b1101111) return 1'b1;
    if (op == 7'b1100111) return f3 == 3'd0;
    if (op == 7'b1100011) return !(f3 == 3'd2 || f3 == 3'd3);
    return 1'b0;
  endfunction

  // Spec rules, evaluated with plain arithmetic on one pack.
  function automatic void ref_presolve(
    input logic [XL-1:0] pc, input logic [FW-1:0] lv, input logic [32*FW-1:0] insts,
    input bit pred, input int sel,
    output bit rdir, output logic [XL-1:0] rpc, output bit rtk, output logic [FW-1:0] keep);
    logic [XL-1:0] base, off;
    logic [31:0] ins;
    logic [20:0] imm21;
    int j, cut;
    base = pc - (pc % XL'(FW * 4));
    j = -1;
    for (int i = 0; i < FW; i++) begin
      ins = insts[32*i +: 32];
      if (j < 0 && lv[i] && ins[6:0] == 7'b1101111) j = i;
    end
    rdir = 1'b0; rtk = 1'b0; rpc = '0; cut = FW;
    if (j >= 0 && (!pred || j < sel)) begin
      ins   = insts[32*j +: 32];
      imm21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      off   = XL'(imm21);
      if (ins[31]) off = off - (XL'(1) << 21);
      rpc = base + XL'(4 * j) + off; rtk = 1'b1; rdir = 1'b1; cut = j;
    end else if (pred && !(lv[sel] && ref_is_cf(insts[32*sel +: 32]))) begin
      rpc = base + XL'(4 * sel) + XL'(4); rdir = 1'b1; cut = sel;
    end else if (pred) begin
      cut = sel;
    end
    keep = lv;
    for (int i = 0; i < FW; i++) if (i > cut) keep[i] = 1'b0;
  endfunction

  function automatic bit m_ready();
    return !io.io_i_flush && (m_wait || !m_valid || io.io_o_pack_ready);
  endfunction

  task automatic model_reset();
    m_valid = 0; m_wait = 0; m_rd_valid = 0; m_rd_taken = 0;
    m_valids = '0; m_pc = '0; m_rd_pc = '0; m_insts = '0; m_cnt = 0;
  endtask

  // Advance model by one clock using current inputs, then clock the DUT.
  task automatic step();
    bit acc, rdir, rtk; logic [XL-1:0] rpc; logic [FW-1:0] keep;
    acc = io.io_i_pack_valid && m_ready();
    ref_presolve(io.io_i_pack_pc, io.io_i_pack_valids, io.io_i_pack_insts,
                 io.io_i_bp_valid && io.io_i_bp_taken, int'(io.io_i_bp_select),
                 rdir, rpc, rtk, keep);
    m_rd_valid = 0;
    if (io.io_i_flush) begin
      m_valid = 0; m_wait = 0;
    end else if (m_wait) begin
      if (io.io_o_pack_ready) m_valid = 0;
      if (io.io_i_redirect_ack) m_wait = 0;
    end else if (acc) begin
      m_valid = 1; m_valids = keep; m_pc = io.io_i_pack_pc; m_insts = io.io_i_pack_insts;
      if (rdir) begin
        m_rd_valid = 1; m_rd_pc = rpc; m_rd_taken = rtk; m_wait = 1;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
    end else if (io.io_o_pack_ready) begin
      m_valid = 0;
    end
    @(posedge clock); #1;
  endtask

  task automatic set_pack(input bit v, input logic [XL-1:0] pc, input logic [FW-1:0] lv,
                          input logic [31:0] i1, input logic [31:0] i0,
                          input bit bpv, input bit bpt, input int sel);
    io.io_i_pack_valid = v; io.io_i_pack_pc = pc; io.io_i_pack_valids = lv;
    io.io_i_pack_insts = {i1, i0};
    io.io_i_bp_valid = bpv; io.io_i_bp_taken = bpt; io.io_i_bp_select = SW'(sel);
  endtask

  task automatic ack_cycle();
    io.io_i_pack_valid = 1'b0; io.io_i_bp_valid = 1'b0; io.io_i_redirect_ack = 1'b1;
    step();
    io.io_i_redirect_ack = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #2;
    n_vec++; if (io.io_o_pack_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", io.io_o_pack_valid); end
    n_vec++; if (io.io_o_redirect_valid !== 1'b0) begin n_err++; $display("FAIL rst_rd_valid got %b want 0", io.io_o_redirect_valid); end
    n_vec++; if (io.io_o_redirect_pc !== 64'h0) begin n_err++; $display("FAIL rst_rd_pc got %h want 0", io.io_o_redirect_pc); end
    n_vec++; if (io.io_o_redirect_count !== 2'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", io.io_o_redirect_count); end
    n_vec++; if (io.io_o_pack_pc !== 64'h0 || io.io_o_pack_valids !== 2'b00) begin n_err++; $display("FAIL rst_pack got pc %h valids %b want 0", io.io_o_pack_pc, io.io_o_pack_valids); end
    model_reset();
    #9 reset_n = 1'b1;
  endtask

  task automatic test_passthrough();
    set_pack(1'b1, 64'h1000, 2'b11, NOP, NOP, 1'b0, 1'b0, 0);
    #1;
    n_vec++; if (io.io_i_pack_ready !== 1'b1) begin n_err++; $display("FAIL t1_ready got %b want 1", io.io_i_pack_ready); end
    step();
    io.io_i_pack_valid = 1'b0;
    n_vec++; if (io.io_o_pack_valid !== 1'b1) begin n_err++; $display("FAIL t1_valid got %b want 1", io.io_o_pack_valid); end
    n_vec++; if (io.io_o_pack_valids !== 2'b11) begin n_err++; $display("FAIL t1_valids got %b want 11", io.io_o_pack_valids); end
    n_vec++; if (io.io_o_pack_pc !== 64'h1000) begin n_err++; $display("FAIL t1_pc got %h want 1000", io.io_o_pack_pc); end
    n_vec++; if (io.io_o_redirect_valid !== 1'b0) begin n_err++; $display("FAIL t1_rd got %b want 0", io.io_o_redirect_valid); end
    step();
    n_vec++; if (io.io_o_pack_valid !== 1'b0) begin n_err++; $display("FAIL t1_drain got %b want 0", io.io_o_pack_valid); end
  endtask

  task automatic test_jal_redirect();
    set_pack(1'b1, 64'h1004, 2'b11, BEQ, enc_jal(21'h000100), 1'b0, 1'b0, 0);
    step();
    n_vec++; if (io.io_o_redirect_valid !== 1'b1) begin n_err++; $display("FAIL t2_rd got %b want 1", io.io_o_redirect_valid); end
    n_vec++; if (io.io_o_redirect_pc !== 64'h1100) begin n_err++; $display("FAIL t2_rd_pc got %h want 1100", io.io_o_redirect_pc); end
    n_vec++; if (io.io_o_redirect_taken !== 1'b1) begin n_err++; $display("FAIL t2_taken got %b want 1", io.io_o_redirect_taken); end
    n_vec++; if (io.io_o_pack_valids !== 2'b01) begin n_err++; $display("FAIL t2_valids got %b want 01", io.io_o_pack_valids); end
    n_vec++; if (io.io_o_redirect_count !== 2'd1) begin n_err++; $display("FAIL t2_count got %0d want 1", io.io_o_redirect_count); end
    set_pack(1'b1, 64'h3000, 2'b11, NOP, NOP, 1'b0, 1'b0, 0);
    #1;
    n_vec++; if (io.io_i_pack_ready !== 1'b1) begin n_err++; $display("FAIL t2_wait_ready got %b want 1", io.io_i_pack_ready); end
    for (int k = 0; k < 2; k++) begin
      step();
      n_vec++; if (io.io_o_pack_valid !== 1'b0 || io.io_o_redirect_valid !== 1'b0) begin n_err++; $display("FAIL t2_drop got v%b rd%b want 0 0", io.io_o_pack_valid, io.io_o_redirect_valid); end
    end
    ack_cycle();
    io.io_i_pack_valid = 1'b1;
    step();
    io.io_i_pack_valid = 1'b0;
    n_vec++; if (io.io_o_pack_valid !== 1'b1 || io.io_o_pack_pc !== 64'h3000) begin n_err++; $display("FAIL t2_resume got v%b pc %h want 1 3000", io.io_o_pack_valid, io.io_o_pack_pc); end
    step();
  endtask

  task automatic test_false_taken();
    set_pack(1'b1, 64'h1000, 2'b11, ADDI, NOP, 1'b1, 1'b1, 1);
    step();
    n_vec++; if (io.io_o_redirect_valid !== 1'b1 || io.io_o_redirect_pc !== 64'h1008) begin n_err++; $display("FAIL t3_rd got v%b pc %h want 1 1008", io.io_o_redirect_valid, io.io_o_redirect_pc); end
    n_vec++; if (io.io_o_redirect_taken !== 1'b0) begin n_err++; $display("FAIL t3_taken got %b want 0", io.io_o_redirect_taken); end
    n_vec++; if (io.io_o_redirect_count !== 2'd2) begin n_err++; $display("FAIL t3_count got %0d want 2", io.io_o_redirect_count); end
    // ack in the pulse cycle: this pack is dropped, the next one flows
    set_pack(1'b1, 64'h4000, 2'b11, NOP, NOP, 1'b0, 1'b0, 0);
    io.io_i_redirect_ack = 1'b1;
    step();
    io.io_i_redirect_ack = 1'b0;
    n_vec++; if (io.io_o_pack_valid !== 1'b0) begin n_err++; $display("FAIL t3_drop got %b want 0", io.io_o_pack_valid); end
    step();
    io.io_i_pack_valid = 1'b0;
    n_vec++; if (io.io_o_pack_valid !== 1'b1 || io.io_o_pack_pc !== 64'h4000) begin n_err++; $display("FAIL t3_ack_same got v%b pc %h want 1 4000", io.io_o_pack_valid, io.io_o_pack_pc); end
    step();
  endtask

  task automatic test_jal_wins();
    set_pack(1'b1, 64'h2000, 2'b11, BNE, enc_jal(21'h1FFFF8), 1'b1, 1'b1, 1);
    step();
    n_vec++; if (io.io_o_redirect_pc !== 64'h1FF8 || io.io_o_redirect_taken !== 1'b1) begin n_err++; $display("FAIL t4_rd got pc %h tk %b want 1ff8 1", io.io_o_redirect_pc, io.io_o_redirect_taken); end
    n_vec++; if (io.io_o_pack_valids !== 2'b01) begin n_err++; $display("FAIL t4_valids got %b want 01", io.io_o_pack_valids); end
    n_vec++; if (io.io_o_redirect_count !== 2'd3) begin n_err++; $display("FAIL t4_count got %0d want 3", io.io_o_redirect_count); end
    ack_cycle();
    step();
  endtask

  task automatic test_stall_flush();
    io.io_o_pack_ready = 1'b0;
    set_pack(1'b1, 64'h5000, 2'b11, NOP, NOP, 1'b0, 1'b0, 0);
    step();
    set_pack(1'b1, 64'h6000, 2'b11, NOP, enc_jal(21'h000040), 1'b0, 1'b0, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++; if (io.io_i_pack_ready !== 1'b0) begin n_err++; $display("FAIL t5_ready got %b want 0", io.io_i_pack_ready); end
      step();
      n_vec++; if (io.io_o_pack_valid !== 1'b1 || io.io_o_pack_pc !== 64'h5000 || io.io_o_redirect_valid !== 1'b0) begin n_err++; $display("FAIL t5_hold got v%b pc %h rd %b want 1 5000 0", io.io_o_pack_valid, io.io_o_pack_pc, io.io_o_redirect_valid); end
    end
    io.io_i_flush = 1'b1;
    #1;
    n_vec++; if (io.io_i_pack_ready !== 1'b0) begin n_err++; $display("FAIL t5_flush_ready got %b want 0", io.io_i_pack_ready); end
    step();
    io.io_i_flush = 1'b0; io.io_i_pack_valid = 1'b0; io.io_o_pack_ready = 1'b1;
    n_vec++; if (io.io_o_pack_valid !== 1'b0 || io.io_o_redirect_valid !== 1'b0) begin n_err++; $display("FAIL t5_flush got v%b rd %b want 0 0", io.io_o_pack_valid, io.io_o_redirect_valid); end
    n_vec++; if (io.io_o_redirect_count !== 2'd3 || io.io_o_redirect_pc !== 64'h1FF8) begin n_err++; $display("FAIL t5_held got cnt %0d pc %h want 3 1ff8", io.io_o_redirect_count, io.io_o_redirect_pc); end
  endtask

  task automatic test_wrap_saturate();
    set_pack(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 2'b11, NOP, enc_jal(21'h000010), 1'b0, 1'b0, 0);
    step();
    n_vec++; if (io.io_o_redirect_valid !== 1'b1 || io.io_o_redirect_pc !== 64'h8) begin n_err++; $display("FAIL t6_wrap got v%b pc %h want 1 8", io.io_o_redirect_valid, io.io_o_redirect_pc); end
    ack_cycle();
    set_pack(1'b1, 64'h1000, 2'b11, ADDI, NOP, 1'b1, 1'b1, 1);
    step();
    n_vec++; if (io.io_o_redirect_valid !== 1'b1 || io.io_o_redirect_count !== 2'd3) begin n_err++; $display("FAIL t6_sat got v%b cnt %0d want 1 3", io.io_o_redirect_valid, io.io_o_redirect_count); end
    ack_cycle();
    step();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [20:0] r;
    r = 21'($urandom);
    case ($urandom_range(0, 8))
      0: return NOP;
      1: return BEQ;
      2: return BNE;
      3: return 32'h0000_2063;
      4: return 32'h0000_3063;
      5: return 32'h0000_8067;
      6: return 32'h0000_9067;
      7: return enc_jal(r);
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      io.io_i_pack_valid   = ($urandom_range(0, 9) < 7);
      io.io_i_pack_pc      = {$urandom, $urandom};
      io.io_i_pack_valids  = FW'($urandom);
      io.io_i_pack_insts   = {rand_inst(), rand_inst()};
      io.io_i_bp_valid     = $urandom_range(0, 1) == 1;
      io.io_i_bp_taken     = $urandom_range(0, 1) == 1;
      io.io_i_bp_select    = SW'($urandom);
      io.io_o_pack_ready   = ($urandom_range(0, 3) != 0);
      io.io_i_redirect_ack = ($urandom_range(0, 2) == 0);
      io.io_i_flush        = ($urandom_range(0, 19) == 0);
      #1;
      n_vec++; if (io.io_i_pack_ready !== m_ready()) begin n_err++; $display("FAIL rnd_ready[%0d] got %b want %b", n, io.io_i_pack_ready, m_ready()); end
      step();
      n_vec++; if (io.io_o_pack_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid[%0d] got %b want %b", n, io.io_o_pack_valid, m_valid); end
      n_vec++; if (io.io_o_pack_valids !== m_valids || io.io_o_pack_pc !== m_pc || io.io_o_pack_insts !== m_insts) begin n_err++; $display("FAIL rnd_pack[%0d] got %b %h %h want %b %h %h", n, io.io_o_pack_valids, io.io_o_pack_pc, io.io_o_pack_insts, m_valids, m_pc, m_insts); end
      n_vec++; if (io.io_o_redirect_valid !== m_rd_valid || io.io_o_redirect_pc !== m_rd_pc || io.io_o_redirect_taken !== m_rd_taken) begin n_err++; $display("FAIL rnd_rd[%0d] got %b %h %b want %b %h %b", n, io.io_o_redirect_valid, io.io_o_redirect_pc, io.io_o_redirect_taken, m_rd_valid, m_rd_pc, m_rd_taken); end
      n_vec++; if (int'(io.io_o_redirect_count) != m_cnt) begin n_err++; $display("FAIL rnd_count[%0d] got %0d want %0d", n, io.io_o_redirect_count, m_cnt); end
    end
    io.io_i_flush = 1'b0; io.io_i_pack_valid = 1'b0; io.io_i_redirect_ack = 1'b0; io.io_o_pack_ready = 1'b1;
  endtask

  task automatic test_async_reset();
    set_pack(1'b1, 64'h7000, 2'b11, NOP, enc_jal(21'h000020), 1'b0, 1'b0, 0);
    step();
    io.io_i_pack_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    n_vec++; if (io.io_o_pack_valid !== 1'b0 || io.io_o_redirect_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got v%b rd %b want 0 0", io.io_o_pack_valid, io.io_o_redirect_valid); end
    n_vec++; if (io.io_o_redirect_pc !== 64'h0 || io.io_o_redirect_count !== 2'd0 || io.io_o_pack_pc !== 64'h0) begin n_err++; $display("FAIL arst_regs got pc %h cnt %0d ppc %h want 0", io.io_o_redirect_pc, io.io_o_redirect_count, io.io_o_pack_pc); end
    model_reset();
    #2 reset_n = 1'b1;
    set_pack(1'b1, 64'h8000, 2'b11, NOP, NOP, 1'b0, 1'b0, 0);
    step();
    io.io_i_pack_valid = 1'b0;
    n_vec++; if (io.io_o_pack_valid !== 1'b1 || io.io_o_pack_pc !== 64'h8000) begin n_err++; $display("FAIL arst_run got v%b pc %h want 1 8000", io.io_o_pack_valid, io.io_o_pack_pc); end
  endtask

  initial begin
    io.io_i_flush = 1'b0; io.io_i_redirect_ack = 1'b0; io.io_o_pack_ready = 1'b1;
    set_pack(1'b0, '0, '0, NOP, NOP, 1'b0, 1'b0, 0);
    test_reset();
    test_passthrough();
    test_jal_redirect();
    test_false_taken();
    test_jal_wins();
    test_stall_flush();
    test_wrap_saturate();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
